// File: rtl/f_pc_unit.sv
// f_pc_unit: fetch-stage program counter with stall-buffered redirect, exception/ERET entry and fetch-fault detection
module f_pc_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IM_BASE = 32'h0000_3000,
  parameter int IDX_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [IDX_W-1:0]  instr_addr,
  output logic              pending,
  output logic              fetch_fault
);
  localparam logic [ADDR_W:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [ADDR_W:0] IM_HI = IM_LO + ((ADDR_W+1)'(1) << (IDX_W + 2));
  logic [ADDR_W-1:0] r_pc, r_tgt, w_pc_nxt, w_tgt_nxt, w_off;
  logic r_pend, w_pend_nxt, w_flush;
  always_comb begin
    w_flush    = exc_req | eret_req;
    w_pc_nxt   = exc_req ? EXC_VECTOR :
                 eret_req ? epc :
                 !en ? r_pc :
                 redirect_valid ? redirect_target :
                 r_pend ? r_tgt : r_pc + ADDR_W'(4);
    // a stalled redirect is parked; any flush or unstalled cycle consumes it
    w_pend_nxt = !w_flush && !en && (redirect_valid || r_pend);
    w_tgt_nxt  = (!w_flush && !en && redirect_valid) ? redirect_target : r_tgt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_VECTOR;
      r_pend <= 1'b0;
      r_tgt  <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pend <= w_pend_nxt;
      r_tgt  <= w_tgt_nxt;
    end
  end
  assign w_off       = r_pc - IM_BASE;
  assign pc          = r_pc;
  assign pending     = r_pend;
  assign instr_addr  = IDX_W'(w_off >> 2);
  assign fetch_fault = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} < IM_LO) || ({1'b0, r_pc} >= IM_HI);
endmodule

// File: tb/tb_f_pc_unit.sv
// tb_f_pc_unit: table-driven directed vectors plus randomized run against a behavioural PC model
module tb_f_pc_unit;
  logic clk = 0, reset, en, redirect_valid, exc_req, eret_req;
  logic [31:0] redirect_target, epc, pc;
  logic [11:0] instr_addr;
  logic pending, fetch_fault;
  int checks = 0, failures = 0;

  typedef struct {
    logic en, rv;
    logic [31:0] tgt;
    logic exc, eret;
    logic [31:0] epc, pc;
    logic pend, fault;
    logic [11:0] idx;
  } vec_t;
  vec_t tbl[$];

  logic [31:0] m_pc, m_buf;
  logic m_pend;

  f_pc_unit dut (
    .clk(clk), .reset(reset), .en(en), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc(pc), .instr_addr(instr_addr), .pending(pending),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rv, input logic [31:0] t,
                      input logic x, input logic er, input logic [31:0] ep);
    reset = r; en = e; redirect_valid = rv; redirect_target = t;
    exc_req = x; eret_req = er; epc = ep;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] p, input logic pd,
                         input logic f, input logic [11:0] ix);
    chk({nm, ".pc"}, pc, p);
    chk({nm, ".pending"}, {31'b0, pending}, {31'b0, pd});
    chk({nm, ".fault"}, {31'b0, fetch_fault}, {31'b0, f});
    chk({nm, ".idx"}, {20'b0, instr_addr}, {20'b0, ix});
  endtask

  function automatic logic exp_fault(input logic [31:0] p);
    longint v = longint'(p);
    return (v % 4 != 0) || (v < 'h3000) || (v >= 'h3000 + 4 * 4096);
  endfunction

  function automatic logic [11:0] exp_idx(input logic [31:0] p);
    longint d = (longint'(p) - 'h3000 + 64'h1_0000_0000) % 64'h1_0000_0000;
    return 12'((d / 4) % 4096);
  endfunction

  // Reference: next PC from the priority rules, with the buffered redirect as a plain slot
  task automatic model(input logic r, input logic e, input logic rv, input logic [31:0] t,
                       input logic x, input logic er, input logic [31:0] ep);
    if (r) begin m_pc = 32'h3000; m_pend = 0; m_buf = 0; end
    else if (x) begin m_pc = 32'h4180; m_pend = 0; end
    else if (er) begin m_pc = ep; m_pend = 0; end
    else if (e) begin
      if (rv) m_pc = t;
      else if (m_pend) m_pc = m_buf;
      else m_pc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
      m_pend = 0;
    end else if (rv) begin m_buf = t; m_pend = 1; end
  endtask

  initial begin
    // en rv tgt exc eret epc -> pc pend fault idx
    tbl.push_back('{1, 0, 0,        0, 0, 0,        'h3004, 0, 0, 'h001});
    tbl.push_back('{1, 0, 0,        0, 0, 0,        'h3008, 0, 0, 'h002});
    tbl.push_back('{1, 0, 0,        0, 0, 0,        'h300C, 0, 0, 'h003});
    tbl.push_back('{0, 1, 'h3100,   0, 0, 0,        'h300C, 1, 0, 'h003});
    tbl.push_back('{0, 0, 0,        0, 0, 0,        'h300C, 1, 0, 'h003});
    tbl.push_back('{0, 0, 0,        0, 0, 0,        'h300C, 1, 0, 'h003});
    tbl.push_back('{1, 0, 0,        0, 0, 0,        'h3100, 0, 0, 'h040});
    tbl.push_back('{0, 1, 'h3100,   0, 0, 0,        'h3100, 1, 0, 'h040});
    tbl.push_back('{0, 1, 'h3200,   0, 0, 0,        'h3100, 1, 0, 'h040});
    tbl.push_back('{0, 0, 0,        1, 0, 0,        'h4180, 0, 0, 'h460});
    tbl.push_back('{0, 1, 'h3100,   0, 0, 0,        'h4180, 1, 0, 'h460});
    tbl.push_back('{0, 1, 'h3200,   0, 0, 0,        'h4180, 1, 0, 'h460});
    tbl.push_back('{1, 0, 0,        0, 0, 0,        'h3200, 0, 0, 'h080});
    tbl.push_back('{1, 0, 0,        1, 1, 'h3050,   'h4180, 0, 0, 'h460});
    tbl.push_back('{1, 0, 0,        0, 1, 'h3050,   'h3050, 0, 0, 'h014});
    tbl.push_back('{0, 1, 'h3300,   0, 0, 0,        'h3050, 1, 0, 'h014});
    tbl.push_back('{0, 0, 0,        0, 1, 'h3060,   'h3060, 0, 0, 'h018});
    tbl.push_back('{1, 0, 0,        0, 0, 0,        'h3064, 0, 0, 'h019});
    tbl.push_back('{1, 1, 'h3002,   0, 0, 0,        'h3002, 0, 1, 'h000});
    tbl.push_back('{1, 1, 'h2FFC,   0, 0, 0,        'h2FFC, 0, 1, 'hFFF});
    tbl.push_back('{1, 1, 'h6FFC,   0, 0, 0,        'h6FFC, 0, 0, 'hFFF});
    tbl.push_back('{1, 1, 'h7000,   0, 0, 0,        'h7000, 0, 1, 'h000});
    tbl.push_back('{0, 1, 'h3300,   0, 0, 0,        'h7000, 1, 1, 'h000});

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk_all("reset", 'h3000, 0, 0, 'h000);
    foreach (tbl[i]) begin
      step(0, tbl[i].en, tbl[i].rv, tbl[i].tgt, tbl[i].exc, tbl[i].eret, tbl[i].epc);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].pend, tbl[i].fault, tbl[i].idx);
    end

    // reset mid-stall with a redirect still buffered
    step(1, 0, 0, 0, 0, 0, 0);
    chk_all("rst_pend", 'h3000, 0, 0, 'h000);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_all("rst_nobuf", 'h3000, 0, 0, 'h000);
    step(0, 1, 1, 'hFFFF_FFFC, 0, 0, 0);
    chk_all("top", 'hFFFF_FFFC, 0, 1, 'h3FF);
    step(0, 1, 0, 0, 0, 0, 0);
    chk_all("wrap", 'h0000_0000, 0, 1, 'h400);

    step(1, 0, 0, 0, 0, 0, 0);
    model(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic r, e, rv, x, er;
      logic [31:0] t, ep;
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 3) == 0);
      x  = ($urandom_range(0, 19) == 0);
      er = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h2F00 + 32'($urandom_range(0, 'h4200));
      ep = 32'h3000 + 32'($urandom_range(0, 'h4000));
      step(r, e, rv, t, x, er, ep);
      model(r, e, rv, t, x, er, ep);
      chk_all($sformatf("rnd%0d", n), m_pc, m_pend, exp_fault(m_pc), exp_idx(m_pc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
